// File: rtl/led_matrix_streamer.sv
// led_matrix_streamer: snapshots a ROWS x COLS RGB332 frame and serialises it
// to a WS2812-style single-wire LED chain as 24-bit GRB words (MSB first),
// followed by a low latch gap. Outputs are registered from the FSM state,
// so every output trails its state by one clock, consistently.
module led_matrix_streamer #(
   parameter int ROWS         = 12,
   parameter int COLS         = 10,
   parameter int T0H_CYC      = 20,
   parameter int T1H_CYC      = 40,
   parameter int BIT_CYC      = 63,
   parameter int LATCH_CYC    = 15000,
   parameter int SERPENTINE   = 1,
   parameter int BRIGHT_SHIFT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   input  logic [0:8*COLS-1] colorValues [0:ROWS-1],
   output logic              led_dout,
   output logic              busy,
   output logic              frame_done
);

   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
   localparam int LAT_W = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SNAPSHOT = 3'd1,
      ST_LOAD     = 3'd2,
      ST_SEND     = 3'd3,
      ST_LATCH    = 3'd4
   } state_t;

   state_t            state_r, state_s;
   logic [ROW_W-1:0]  row_r, row_s;
   logic [COL_W-1:0]  k_r, k_s;
   logic [4:0]        bit_idx_r, bit_idx_s;
   logic [CYC_W-1:0]  cyc_r, cyc_s;
   logic [LAT_W-1:0]  lat_r, lat_s;
   logic [23:0]       shift_r, shift_s;
   logic [0:8*COLS-1] frame_buf_r [0:ROWS-1];

   logic [COL_W-1:0]  col_s;
   logic [7:0]        pix_s;
   logic              last_pix_s;
   logic [CYC_W-1:0]  high_lim_s;
   logic              dout_s;
   logic              busy_s;
   logic              done_s;

   // RGB332 -> 24-bit GRB with bit replication, then brightness scaling
   function automatic logic [23:0] expand_pixel(input logic [7:0] p);
      logic [7:0] r8;
      logic [7:0] g8;
      logic [7:0] b8;
      r8 = {p[7:5], p[7:5], p[7:6]} >> BRIGHT_SHIFT;
      g8 = {p[4:2], p[4:2], p[4:3]} >> BRIGHT_SHIFT;
      b8 = {p[1:0], p[1:0], p[1:0], p[1:0]} >> BRIGHT_SHIFT;
      return {g8, r8, b8};
   endfunction

   // select byte 'col' from one buffered row; bit 8*c of the row is the byte MSB
   function automatic logic [7:0] fetch_pixel(input logic [0:8*COLS-1] row_bits,
                                               input logic [COL_W-1:0]  col);
      logic [7:0] p;
      p = 8'h00;
      for (int c = 0; c < COLS; c++) begin
         if (col == COL_W'(c)) begin
            p = row_bits[8*c +: 8];
         end
      end
      return p;
   endfunction

   // pixel addressing: serpentine wiring reverses odd rows
   always_comb begin
      col_s      = k_r;
      if ((SERPENTINE != 0) && row_r[0]) begin
         col_s = COL_W'(COLS - 1) - k_r;
      end else begin
         col_s = k_r;
      end
      pix_s      = fetch_pixel(frame_buf_r[row_r], col_s);
      last_pix_s = (row_r == ROW_W'(ROWS - 1)) && (k_r == COL_W'(COLS - 1));
   end

   // next-state and counter logic for the streaming FSM
   always_comb begin
      state_s   = state_r;
      row_s     = row_r;
      k_s       = k_r;
      bit_idx_s = bit_idx_r;
      cyc_s     = cyc_r;
      lat_s     = lat_r;
      shift_s   = shift_r;
      case (state_r)
         ST_IDLE: begin
            if (enable) begin
               state_s = ST_SNAPSHOT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SNAPSHOT: begin
            row_s   = '0;
            k_s     = '0;
            state_s = ST_LOAD;
         end
         ST_LOAD: begin
            shift_s   = expand_pixel(pix_s);
            bit_idx_s = 5'd0;
            cyc_s     = '0;
            state_s   = ST_SEND;
         end
         ST_SEND: begin
            if (cyc_r == CYC_W'(BIT_CYC - 1)) begin
               cyc_s   = '0;
               shift_s = {shift_r[22:0], 1'b0};
               if (bit_idx_r == 5'd23) begin
                  if (last_pix_s) begin
                     lat_s   = '0;
                     state_s = ST_LATCH;
                  end else begin
                     state_s = ST_LOAD;
                     if (k_r == COL_W'(COLS - 1)) begin
                        k_s   = '0;
                        row_s = row_r + ROW_W'(1);
                     end else begin
                        k_s = k_r + COL_W'(1);
                     end
                  end
               end else begin
                  bit_idx_s = bit_idx_r + 5'd1;
               end
            end else begin
               cyc_s = cyc_r + CYC_W'(1);
            end
         end
         ST_LATCH: begin
            if (lat_r == LAT_W'(LATCH_CYC - 1)) begin
               lat_s = '0;
               if (enable) begin
                  state_s = ST_SNAPSHOT;
               end else begin
                  state_s = ST_IDLE;
               end
            end else begin
               lat_s = lat_r + LAT_W'(1);
            end
         end
         default: begin
            state_s = ST_IDLE;
         end
      endcase
   end

   // output decode from the current state, registered below
   always_comb begin
      if (shift_r[23]) begin
         high_lim_s = CYC_W'(T1H_CYC);
      end else begin
         high_lim_s = CYC_W'(T0H_CYC);
      end
      dout_s = (state_r == ST_SEND) && (cyc_r < high_lim_s);
      busy_s = (state_r != ST_IDLE);
      done_s = (state_r == ST_LATCH) && (lat_r == LAT_W'(LATCH_CYC - 1));
   end

   // FSM state and counter registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r   <= ST_IDLE;
         row_r     <= '0;
         k_r       <= '0;
         bit_idx_r <= 5'd0;
         cyc_r     <= '0;
         lat_r     <= '0;
         shift_r   <= 24'h000000;
      end else begin
         state_r   <= state_s;
         row_r     <= row_s;
         k_r       <= k_s;
         bit_idx_r <= bit_idx_s;
         cyc_r     <= cyc_s;
         lat_r     <= lat_s;
         shift_r   <= shift_s;
      end
   end

   // frame snapshot so later input changes cannot tear the frame in flight
   always_ff @(posedge clk) begin
      if (state_r == ST_SNAPSHOT) begin
         frame_buf_r <= colorValues;
      end
   end

   // registered outputs; nothing reaches the pin combinationally
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         led_dout   <= 1'b0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         led_dout   <= dout_s;
         busy       <= busy_s;
         frame_done <= done_s;
      end
   end

endmodule
